// File: rtl/muxn_pipe.sv
// muxn_pipe
// N-input, WIDTH-bit select stage with valid/ready flow control.
// With PIPE=1 the selected beat is registered into a main register backed
// by a one-entry skid register, so in_ready comes straight from a flop and
// the stage still sustains one beat per cycle under back-pressure.
// With PIPE=0 the stage is a purely combinational N-way select.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_data    packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel     binary select, sampled together with in_data
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle
//   flush      discard every beat held in the stage
//   out_data   selected data
//   out_sel    select value that produced out_data
//   out_err    in_sel was out of range for this beat
//   out_valid  output beat present
//   out_ready  downstream accepts
module muxn_pipe #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int PIPE   = 1,
   localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [WIDTH-1:0] selData;
   logic             selErr;

   // The N-way select. An out-of-range select yields zero data and raises
   // the error flag; the beat itself still travels through the stage so the
   // consumer sees the error alongside the select that caused it.
   always_comb begin
      selData = '0;
      selErr  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            selData = in_data[k*WIDTH +: WIDTH];
            selErr  = 1'b0;
         end
      end
   end

   if (PIPE != 0) begin : gPipe
      // Occupancy of the stage: main register only, or main plus skid.
      typedef enum logic [1:0] {
         EMPTY = 2'b00,
         ONE   = 2'b01,
         FULL  = 2'b11
      } stateT;

      stateT            state_q, state_d;
      logic [WIDTH-1:0] mData_q, mData_d, sData_q, sData_d;
      logic [SEL_W-1:0] mSel_q, mSel_d, sSel_q, sSel_d;
      logic             mErr_q, mErr_d, sErr_q, sErr_d;
      logic             inXfer, outXfer;

      // in_ready depends only on the registered state, never on out_ready,
      // which is what lets this stage break the ready timing path.
      assign inXfer  = in_valid && (state_q != FULL);
      assign outXfer = (state_q != EMPTY) && out_ready;

      // Next-state logic. Registers hold by default and only load on a
      // transfer; a flush empties the stage and drops whatever was offered
      // in the same cycle. When a beat arrives while the main register is
      // stalled it parks in the skid register and is promoted on the next
      // output transfer, so no bubble appears when out_ready rises.
      always_comb begin
         state_d = state_q;
         mData_d = mData_q;
         mSel_d  = mSel_q;
         mErr_d  = mErr_q;
         sData_d = sData_q;
         sSel_d  = sSel_q;
         sErr_d  = sErr_q;
         if (flush) begin
            state_d = EMPTY;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (inXfer) begin
                     mData_d = selData;
                     mSel_d  = in_sel;
                     mErr_d  = selErr;
                     state_d = ONE;
                  end
               end
               ONE: begin
                  if (outXfer && inXfer) begin
                     mData_d = selData;
                     mSel_d  = in_sel;
                     mErr_d  = selErr;
                  end else if (outXfer) begin
                     state_d = EMPTY;
                  end else if (inXfer) begin
                     sData_d = selData;
                     sSel_d  = in_sel;
                     sErr_d  = selErr;
                     state_d = FULL;
                  end
               end
               FULL: begin
                  if (outXfer) begin
                     mData_d = sData_q;
                     mSel_d  = sSel_q;
                     mErr_d  = sErr_q;
                     state_d = ONE;
                  end
               end
               default: begin
                  state_d = EMPTY;
               end
            endcase
         end
      end

      // State register. Reset empties the stage and zeroes both data
      // registers so out_* read as zero straight after reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= EMPTY;
            mData_q <= '0;
            mSel_q  <= '0;
            mErr_q  <= 1'b0;
            sData_q <= '0;
            sSel_q  <= '0;
            sErr_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            mData_q <= mData_d;
            mSel_q  <= mSel_d;
            mErr_q  <= mErr_d;
            sData_q <= sData_d;
            sSel_q  <= sSel_d;
            sErr_q  <= sErr_d;
         end
      end

      assign in_ready  = (state_q != FULL);
      assign out_valid = (state_q != EMPTY);
      assign out_data  = mData_q;
      assign out_sel   = mSel_q;
      assign out_err   = mErr_q;
   end else begin : gComb
      // Combinational passthrough: no state, ready flows straight upstream.
      assign in_ready  = out_ready;
      assign out_valid = in_valid && !flush;
      assign out_data  = selData;
      assign out_sel   = in_sel;
      assign out_err   = selErr;
   end

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe
// Drives three muxn_pipe instances from shared stimulus:
//   A: PIPE=1, NUM_IN=4   B: PIPE=1, NUM_IN=3   C: PIPE=0, NUM_IN=3
// Accepted beats are pushed as expected results into per-instance queues;
// a monitor on the falling edge compares what each stage presents.
module tb_muxn_pipe;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] sel;
      logic       err;
   } beatT;

   logic        clk = 1'b0;
   logic        rst, flush, inValid, outReady;
   logic [1:0]  inSel;
   logic [31:0] inData;

   logic [7:0]  outDataA, outDataB, outDataC;
   logic [1:0]  outSelA, outSelB, outSelC;
   logic        outErrA, outErrB, outErrC;
   logic        outValidA, outValidB, outValidC;
   logic        inReadyA, inReadyB, inReadyC;

   int   tests = 0;
   int   failures = 0;
   logic armed = 1'b0;
   beatT expQA[$];
   beatT expQB[$];

   always #5 clk = ~clk;

   muxn_pipe #(.WIDTH(8), .NUM_IN(4), .PIPE(1)) dutA (
      .clk(clk), .rst(rst), .in_data(inData), .in_sel(inSel),
      .in_valid(inValid), .in_ready(inReadyA), .flush(flush),
      .out_data(outDataA), .out_sel(outSelA), .out_err(outErrA),
      .out_valid(outValidA), .out_ready(outReady)
   );

   muxn_pipe #(.WIDTH(8), .NUM_IN(3), .PIPE(1)) dutB (
      .clk(clk), .rst(rst), .in_data(inData[23:0]), .in_sel(inSel),
      .in_valid(inValid), .in_ready(inReadyB), .flush(flush),
      .out_data(outDataB), .out_sel(outSelB), .out_err(outErrB),
      .out_valid(outValidB), .out_ready(outReady)
   );

   muxn_pipe #(.WIDTH(8), .NUM_IN(3), .PIPE(0)) dutC (
      .clk(clk), .rst(rst), .in_data(inData[23:0]), .in_sel(inSel),
      .in_valid(inValid), .in_ready(inReadyC), .flush(flush),
      .out_data(outDataC), .out_sel(outSelC), .out_err(outErrC),
      .out_valid(outValidC), .out_ready(outReady)
   );

   // Reference select: lane 'sel' of the byte-packed inputs if it exists,
   // otherwise zero with the error flag.
   function automatic beatT refSelect(logic [31:0] data, logic [1:0] sel, int n);
      beatT r;
      r.sel = sel;
      if (int'(sel) < n) begin
         r.data = data[sel*8 +: 8];
         r.err  = 1'b0;
      end else begin
         r.data = 8'h00;
         r.err  = 1'b1;
      end
      return r;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Compares one registered stage against its expected queue of held beats.
   function automatic void checkSide(string tag, logic valid, logic [7:0] data,
                                     logic [1:0] sel, logic err, logic ready,
                                     int held, beatT front);
      check({tag, "_out_valid"}, 32'(valid), 32'(held > 0));
      check({tag, "_in_ready"}, 32'(ready), 32'(held < 2));
      if (held > 0) begin
         check({tag, "_out_data"}, 32'(data), 32'(front.data));
         check({tag, "_out_sel"}, 32'(sel), 32'(front.sel));
         check({tag, "_out_err"}, 32'(err), 32'(front.err));
      end
   endfunction

   // Monitor: inputs are stable at the falling edge, so this is where
   // the presented beats are compared and the queues follow what the
   // coming rising edge will do (pop on output transfer, clear on flush/reset).
   always @(negedge clk) begin
      beatT c;
      if (armed) begin
         checkSide("A", outValidA, outDataA, outSelA, outErrA, inReadyA,
                   expQA.size(), (expQA.size() > 0) ? expQA[0] : beatT'('0));
         checkSide("B", outValidB, outDataB, outSelB, outErrB, inReadyB,
                   expQB.size(), (expQB.size() > 0) ? expQB[0] : beatT'('0));
         if (rst || flush) begin
            expQA.delete();
            expQB.delete();
         end else if (outReady) begin
            if (expQA.size() > 0) void'(expQA.pop_front());
            if (expQB.size() > 0) void'(expQB.pop_front());
         end
         c = refSelect(inData, inSel, 3);
         check("C_out_data", 32'(outDataC), 32'(c.data));
         check("C_out_sel", 32'(outSelC), 32'(c.sel));
         check("C_out_err", 32'(outErrC), 32'(c.err));
         check("C_out_valid", 32'(outValidC), 32'(inValid && !flush));
         check("C_in_ready", 32'(inReadyC), 32'(outReady));
      end
   end

   // Drives one cycle of inputs, decides from the expected occupancy
   // whether the beat is accepted, and records it after the edge.
   task automatic applyStimulus(input logic v, input logic [1:0] s,
                                input logic [31:0] d, input logic f,
                                input logic r, input logic rs);
      logic accept;
      inValid  = v;
      inSel    = s;
      inData   = d;
      flush    = f;
      outReady = r;
      rst      = rs;
      accept   = v && !f && !rs && (expQA.size() < 2);
      @(posedge clk);
      if (accept) begin
         expQA.push_back(refSelect(d, s, 4));
         expQB.push_back(refSelect(d, s, 3));
      end
      #1;
   endtask

   // Values both registered stages must show right after a reset edge.
   task automatic checkOutput();
      check("A_reset_valid", 32'(outValidA), 32'd0);
      check("A_reset_data", 32'(outDataA), 32'd0);
      check("A_reset_sel", 32'(outSelA), 32'd0);
      check("A_reset_err", 32'(outErrA), 32'd0);
      check("A_reset_ready", 32'(inReadyA), 32'd1);
      check("B_reset_valid", 32'(outValidB), 32'd0);
      check("B_reset_data", 32'(outDataB), 32'd0);
      check("B_reset_ready", 32'(inReadyB), 32'd1);
   endtask

   initial begin
      // Reset
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput();
      armed = 1'b1;

      // Basic select into a free-running output
      applyStimulus(1'b1, 2'd2, 32'h44332211, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd0, 32'h44332211, 1'b0, 1'b1, 1'b0);
      check("basic_A_data", 32'(outDataA), 32'h11);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Back-pressure: A and B fill the stage, C waits, then drains
      applyStimulus(1'b1, 2'd0, {4{8'hA1}}, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, {4{8'hB2}}, 1'b0, 1'b0, 1'b0);
      check("bp_A_in_ready_low", 32'(inReadyA), 32'd0);
      applyStimulus(1'b1, 2'd0, {4{8'hC3}}, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, {4{8'hC3}}, 1'b0, 1'b0, 1'b0);
      check("bp_A_hold", 32'(outDataA), 32'hA1);
      applyStimulus(1'b1, 2'd0, {4{8'hC3}}, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd0, {4{8'hC3}}, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Illegal select on the three-input stage, then a legal one
      applyStimulus(1'b1, 2'd3, 32'h5A6B7C8D, 1'b0, 1'b1, 1'b0);
      check("illegal_B_err", 32'(outErrB), 32'd1);
      applyStimulus(1'b1, 2'd1, 32'h5A6B7C8D, 1'b0, 1'b1, 1'b0);
      check("legal_B_err", 32'(outErrB), 32'd0);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Flush while FULL with a beat offered
      applyStimulus(1'b1, 2'd1, 32'h01020304, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd2, 32'h05060708, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 32'hDDDDDDDD, 1'b1, 1'b0, 1'b0);
      check("flush_A_valid", 32'(outValidA), 32'd0);
      check("flush_A_ready", 32'(inReadyA), 32'd1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Reset while holding one beat, then resume streaming
      applyStimulus(1'b1, 2'd3, 32'hEE000000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput();
      applyStimulus(1'b1, 2'd1, 32'h00009900, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(($urandom_range(9) < 7), 2'($urandom_range(3)), $urandom,
                       ($urandom_range(31) == 0), ($urandom_range(3) != 0),
                       ($urandom_range(99) == 0));
      end

      // Drain
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
